mmcm_reset_seq: RTL and testbench

MMCM_RESET_SEQ -- requirements
Module: mmcm_reset_seq

---
 rtl/rst_seq_pkg.sv | 29 ++
 rtl/sync_debounce.sv | 47 ++++
 rtl/mmcm_reset_seq.sv | 159 +++++++++++++++
 tb/tb_mmcm_reset_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared state encoding and default timing constants for the MMCM reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_MMCM_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_PERIPH    = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  localparam int DEF_MMCM_RST_CYCLES = 8;
  localparam int DEF_LOCK_TIMEOUT    = 4096;
  localparam int DEF_PERIPH_DELAY    = 64;
  localparam int DEF_CORE_DELAY      = 64;
  localparam int DEF_DEBOUNCE_CYCLES = 1024;

  localparam logic [3:0] RETRY_MAX = 4'd15;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a level debouncer: the output only follows
// the synchronized input after it has differed for DEBOUNCE_CYCLES straight cycles.
module sync_debounce
  import rst_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          db;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      db   <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      // Any cycle where the input agrees with the accepted level restarts the run.
      if (sync != db) begin
        if (cnt == LAST) begin
          db  <= sync;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign level = db;

endmodule

// File: rtl/mmcm_reset_seq.sv
// Board-level reset sequencer: pulses the MMCM reset, waits for a stable lock,
// then releases peripheral and core resets in order, retrying on timeout or lock loss.
module mmcm_reset_seq
  import rst_seq_pkg::*;
#(
  parameter int MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int PERIPH_DELAY    = DEF_PERIPH_DELAY,
  parameter int CORE_DELAY      = DEF_CORE_DELAY,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_rst_i,
  input  logic       locked_i,
  output logic       mmcm_rst_o,
  output logic       periph_rst_n_o,
  output logic       core_rst_n_o,
  output logic       ready_o,
  output logic [3:0] retry_cnt_o
);

  localparam int MAX_DELAY = max_of4(MMCM_RST_CYCLES, LOCK_TIMEOUT, PERIPH_DELAY, CORE_DELAY);
  localparam int CNT_W     = $clog2(MAX_DELAY) + 1;

  localparam logic [CNT_W-1:0] MMCM_LAST   = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       retry_nxt;
  logic             retry_inc;

  logic locked_m;
  logic locked_s;
  logic btn_db;

  logic mmcm_rst_nxt;
  logic periph_rst_n_nxt;
  logic core_rst_n_nxt;
  logic ready_nxt;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_rst_i),
    .level(btn_db)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked_i;
      locked_s <= locked_m;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    retry_inc = 1'b0;

    // The button overrides everything, including a simultaneous lock loss.
    if (btn_db) begin
      state_nxt = ST_MMCM_RST;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_MMCM_RST: begin
          if (cnt == MMCM_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt = ST_MMCM_RST;
            cnt_nxt   = '0;
            retry_inc = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!locked_s) begin
            state_nxt = ST_MMCM_RST;
            cnt_nxt   = '0;
            retry_inc = 1'b1;
          end else if (cnt == PERIPH_LAST) begin
            state_nxt = ST_PERIPH;
            cnt_nxt   = '0;
          end
        end
        ST_PERIPH: begin
          if (!locked_s) begin
            state_nxt = ST_MMCM_RST;
            cnt_nxt   = '0;
            retry_inc = 1'b1;
          end else if (cnt == CORE_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end
        ST_RUN: begin
          cnt_nxt = '0;
          if (!locked_s) begin
            state_nxt = ST_MMCM_RST;
            retry_inc = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_MMCM_RST;
          cnt_nxt   = '0;
        end
      endcase
    end

    retry_nxt = retry_cnt_o;
    if (retry_inc && (retry_cnt_o != RETRY_MAX)) begin
      retry_nxt = retry_cnt_o + 4'd1;
    end

    // Outputs follow the state being entered so they switch in the same edge.
    mmcm_rst_nxt     = (state_nxt == ST_MMCM_RST);
    periph_rst_n_nxt = (state_nxt == ST_PERIPH) || (state_nxt == ST_RUN);
    core_rst_n_nxt   = (state_nxt == ST_RUN);
    ready_nxt        = (state_nxt == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_MMCM_RST;
      cnt            <= '0;
      retry_cnt_o    <= 4'd0;
      mmcm_rst_o     <= 1'b1;
      periph_rst_n_o <= 1'b0;
      core_rst_n_o   <= 1'b0;
      ready_o        <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      retry_cnt_o    <= retry_nxt;
      mmcm_rst_o     <= mmcm_rst_nxt;
      periph_rst_n_o <= periph_rst_n_nxt;
      core_rst_n_o   <= core_rst_n_nxt;
      ready_o        <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_mmcm_reset_seq.sv
// Bench for mmcm_reset_seq: table of input/expected-output steps fed through an
// expectation queue, plus hand-written async-reset and lock-timeout sequences.
module tb_mmcm_reset_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_rst_i = 1'b0;
  logic       locked_i = 1'b0;
  logic       mmcm_rst_o;
  logic       periph_rst_n_o;
  logic       core_rst_n_o;
  logic       ready_o;
  logic [3:0] retry_cnt_o;

  typedef struct packed {
    logic       mmcm;
    logic       periph;
    logic       core;
    logic       ready;
    logic [3:0] retry;
  } outs_t;

  typedef struct {
    int    n;
    logic  btn;
    logic  locked;
    outs_t exp;
  } vec_t;

  vec_t  vecs[$];
  outs_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  mmcm_reset_seq #(
    .MMCM_RST_CYCLES(4),
    .LOCK_TIMEOUT   (32),
    .PERIPH_DELAY   (8),
    .CORE_DELAY     (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_rst_i     (btn_rst_i),
    .locked_i      (locked_i),
    .mmcm_rst_o    (mmcm_rst_o),
    .periph_rst_n_o(periph_rst_n_o),
    .core_rst_n_o  (core_rst_n_o),
    .ready_o       (ready_o),
    .retry_cnt_o   (retry_cnt_o)
  );

  // Core must never leave reset while peripherals are still held.
  always @(negedge clk) begin
    if (rst_n && core_rst_n_o && !periph_rst_n_o) begin
      errors++;
      $display("FAIL order_check: got core_rst_n=1 periph_rst_n=0, expected core released only after periph");
    end
  end

  function automatic outs_t mk(input logic m, input logic p, input logic c, input logic r, input int rt);
    outs_t o;
    o.mmcm = m; o.periph = p; o.core = c; o.ready = r; o.retry = 4'(rt);
    return o;
  endfunction

  task automatic add(input int n, input logic b, input logic l,
                     input logic m, input logic p, input logic c, input logic r, input int rt);
    vec_t v;
    v.n = n; v.btn = b; v.locked = l; v.exp = mk(m, p, c, r, rt);
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name);
    outs_t got;
    outs_t want;
    got = {mmcm_rst_o, periph_rst_n_o, core_rst_n_o, ready_o, retry_cnt_o};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got an output sample, expected queue was empty", name);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got mmcm=%b periph=%b core=%b ready=%b retry=%0d, expected mmcm=%b periph=%b core=%b ready=%b retry=%0d",
                 name, got.mmcm, got.periph, got.core, got.ready, got.retry,
                 want.mmcm, want.periph, want.core, want.ready, want.retry);
      end
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cur;

    // Edge numbers in comments count rising edges after rst_n release.
    add(3, 0, 0, 1, 0, 0, 0, 0);   // e3   MMCM reset still held
    add(1, 0, 0, 0, 0, 0, 0, 0);   // e4   WAIT_LOCK
    add(6, 0, 0, 0, 0, 0, 0, 0);   // e10  then locked_i rises
    add(10, 0, 1, 0, 0, 0, 0, 0);  // e20  HOLD since e13
    add(1, 0, 1, 0, 1, 0, 0, 0);   // e21  PERIPH
    add(7, 0, 1, 0, 1, 0, 0, 0);   // e28
    add(1, 0, 1, 0, 1, 1, 1, 0);   // e29  RUN
    add(5, 0, 1, 0, 1, 1, 1, 0);   // e34
    add(1, 0, 0, 0, 1, 1, 1, 0);   // e35  one-cycle lock drop
    add(1, 0, 1, 0, 1, 1, 1, 0);   // e36
    add(1, 0, 1, 1, 0, 0, 0, 1);   // e37  lock loss seen
    add(3, 0, 1, 1, 0, 0, 0, 1);   // e40
    add(1, 0, 1, 0, 0, 0, 0, 1);   // e41  WAIT_LOCK, HOLD from e42
    add(8, 0, 1, 0, 0, 0, 0, 1);   // e49
    add(1, 0, 1, 0, 1, 0, 0, 1);   // e50  PERIPH
    add(7, 0, 1, 0, 1, 0, 0, 1);   // e57
    add(1, 0, 1, 0, 1, 1, 1, 1);   // e58  RUN again
    add(3, 1, 1, 0, 1, 1, 1, 1);   // e61  3-cycle glitch
    add(10, 0, 1, 0, 1, 1, 1, 1);  // e71  glitch ignored
    add(6, 1, 1, 0, 1, 1, 1, 1);   // e77  press, btn_db not yet seen
    add(1, 1, 1, 1, 0, 0, 0, 1);   // e78  button reset
    add(3, 1, 1, 1, 0, 0, 0, 1);   // e81  ten cycles pressed
    add(6, 0, 1, 1, 0, 0, 0, 1);   // e87  btn_db falls here
    add(3, 0, 1, 1, 0, 0, 0, 1);   // e90
    add(1, 0, 1, 0, 0, 0, 0, 1);   // e91  resume
    add(1, 0, 1, 0, 0, 0, 0, 1);   // e92  HOLD
    add(7, 0, 1, 0, 0, 0, 0, 1);   // e99
    add(1, 0, 1, 0, 1, 0, 0, 1);   // e100 PERIPH
    add(4, 1, 1, 0, 1, 0, 0, 1);   // e104 press
    add(1, 1, 0, 0, 1, 0, 0, 1);   // e105 lock drop lined up with btn_db
    add(1, 1, 1, 0, 1, 0, 0, 1);   // e106
    add(1, 1, 1, 1, 0, 0, 0, 1);   // e107 coincident: no increment
    add(2, 0, 1, 1, 0, 0, 0, 1);   // e109

    rst_n = 1'b0;
    step(3);
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    check("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      btn_rst_i = vecs[i].btn;
      locked_i  = vecs[i].locked;
      exp_q.push_back(vecs[i].exp);
      step(vecs[i].n);
      check($sformatf("vec%0d", i));
    end

    // Asynchronous reset taking effect mid-PERIPH.
    btn_rst_i = 1'b0;
    locked_i  = 1'b1;
    rst_n     = 1'b0;
    #1;
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    check("async_reset_clears_retry");
    step(3);
    rst_n = 1'b1;
    exp_q.push_back(mk(0, 1, 0, 0, 0));
    step(15);
    check("periph_before_pulse");
    #2;
    rst_n = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    #1;
    check("async_reset_mid_periph");

    // Lock timeout with retry saturation.
    locked_i = 1'b0;
    step(2);
    rst_n = 1'b1;
    cur = 0;
    for (int n = 1; n <= 17; n++) begin
      exp_q.push_back(mk(0, 0, 0, 0, sat15(n - 1)));
      step(36 * n - 1 - cur);
      check($sformatf("timeout%0d_before", n));
      exp_q.push_back(mk(1, 0, 0, 0, sat15(n)));
      step(1);
      check($sformatf("timeout%0d_edge", n));
      exp_q.push_back(mk(1, 0, 0, 0, sat15(n)));
      step(3);
      check($sformatf("timeout%0d_pulse", n));
      exp_q.push_back(mk(0, 0, 0, 0, sat15(n)));
      step(1);
      check($sformatf("timeout%0d_pulse_end", n));
      cur = 36 * n + 4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
